// File: rtl/alarm_clock_core.sv
// Alarm clock time-keeping and key-entry engine: 24h BCD clock, alarm register, 4-digit key buffer.
// Optional ALARM_KEY_TIMEOUT_EN abandons an unfinished key entry after KEY_TIMEOUT_CYCLES idle cycles.
module alarm_clock_core #(
   parameter int CLOCKS_PER_MINUTE  = 6000,
   parameter int KEY_TIMEOUT_CYCLES = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  key,
   input  logic        key_valid,
   input  logic        load_alarm,
   input  logic        load_new_time,
   input  logic        alarm_button,
   output logic [15:0] current_time,
   output logic [15:0] alarm_time,
   output logic [15:0] key_buffer,
   output logic        show_a,
   output logic        show_new_time,
   output logic        load_error,
   output logic        minute_tick
);

   localparam int CNT_W = (CLOCKS_PER_MINUTE > 2) ? $clog2(CLOCKS_PER_MINUTE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_MINUTE - 1);

   if (CLOCKS_PER_MINUTE < 2 || KEY_TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("alarm_clock_core: CLOCKS_PER_MINUTE must be >= 2 and KEY_TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ENTRY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       time_q, time_d;
   logic [15:0]       alarm_q, alarm_d;
   logic [15:0]       buf_q, buf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              show_a_q;
   logic              err_q, err_d;
   logic              tick_q, tick_d;
   logic              digit_strobe;
   logic              load_any;
   logic              time_loaded;

`ifdef ALARM_KEY_TIMEOUT_EN
   localparam int TO_W = (KEY_TIMEOUT_CYCLES > 1) ? $clog2(KEY_TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(KEY_TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]   idle_q, idle_d;
`endif

   // 24-hour BCD increment; 23:59 rolls to 00:00.
   function automatic logic [15:0] inc_time(input logic [15:0] t);
      logic [3:0] h1, h0, m1, m0;
      {h1, h0, m1, m0} = t;
      if (m0 != 4'd9) begin
         m0 = m0 + 4'd1;
      end else begin
         m0 = 4'd0;
         if (m1 != 4'd5) begin
            m1 = m1 + 4'd1;
         end else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
               h1 = 4'd0;
               h0 = 4'd0;
            end else if (h0 != 4'd9) begin
               h0 = h0 + 4'd1;
            end else begin
               h0 = 4'd0;
               h1 = h1 + 4'd1;
            end
         end
      end
      return {h1, h0, m1, m0};
   endfunction

   function automatic logic buf_valid(input logic [15:0] b);
      logic ok;
      ok = (b[15:12] <= 4'd2) && (b[11:8] <= 4'd9) && (b[7:4] <= 4'd5) && (b[3:0] <= 4'd9);
      if (b[15:12] == 4'd2 && b[11:8] > 4'd3) ok = 1'b0;
      return ok;
   endfunction

   assign digit_strobe = key_valid && (key <= 4'd9);
   assign load_any     = load_new_time || load_alarm;

   always_comb begin
      state_d     = state_q;
      time_d      = time_q;
      alarm_d     = alarm_q;
      buf_d       = buf_q;
      err_d       = 1'b0;
      tick_d      = 1'b0;
      time_loaded = 1'b0;
      cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
`ifdef ALARM_KEY_TIMEOUT_EN
      idle_d      = '0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (digit_strobe) begin
               buf_d   = {buf_q[11:0], key};
               state_d = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            // A load consumes the pre-shift buffer; a coincident key is dropped.
            if (load_any) begin
               buf_d   = '0;
               state_d = ST_IDLE;
               if (buf_valid(buf_q)) begin
                  if (load_new_time) begin
                     time_d      = buf_q;
                     time_loaded = 1'b1;
                  end else begin
                     alarm_d = buf_q;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end else if (key_valid) begin
               if (digit_strobe) buf_d = {buf_q[11:0], key};
`ifdef ALARM_KEY_TIMEOUT_EN
            end else if (idle_q == TO_LAST) begin
               buf_d   = '0;
               state_d = ST_IDLE;
            end else begin
               idle_d = idle_q + TO_W'(1);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A successful time load overrides the minute increment and restarts the prescaler.
      if (time_loaded) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         time_d = inc_time(time_q);
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         time_q   <= '0;
         alarm_q  <= '0;
         buf_q    <= '0;
         cnt_q    <= '0;
         show_a_q <= 1'b0;
         err_q    <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         time_q   <= time_d;
         alarm_q  <= alarm_d;
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         show_a_q <= alarm_button;
         err_q    <= err_d;
         tick_q   <= tick_d;
      end
   end

`ifdef ALARM_KEY_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`endif

   assign current_time  = time_q;
   assign alarm_time    = alarm_q;
   assign key_buffer    = buf_q;
   assign show_a        = show_a_q;
   assign show_new_time = (state_q == ST_ENTRY);
   assign load_error    = err_q;
   assign minute_tick   = tick_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed scenarios plus randomized traffic against a minute-count model.
module tb_alarm_clock_core;

   localparam int CPM = 4;
   localparam int TO  = 10;

   logic        clock, reset;
   logic [3:0]  key;
   logic        key_valid, load_alarm, load_new_time, alarm_button;
   logic [15:0] current_time, alarm_time, key_buffer;
   logic        show_a, show_new_time, load_error, minute_tick;

   alarm_clock_core #(.CLOCKS_PER_MINUTE(CPM), .KEY_TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .key(key), .key_valid(key_valid),
      .load_alarm(load_alarm), .load_new_time(load_new_time), .alarm_button(alarm_button),
      .current_time(current_time), .alarm_time(alarm_time), .key_buffer(key_buffer),
      .show_a(show_a), .show_new_time(show_new_time), .load_error(load_error),
      .minute_tick(minute_tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: time and alarm held as minutes since midnight, entry as a digit list.
   int m_min, m_alarm, m_pre, m_idle;
   int m_dig[$];
   bit m_entry, m_err, m_tick, m_show_a;
   int n_tests, n_fail;

   function automatic logic [15:0] bcd_of(input int minutes);
      int h, m;
      h = minutes / 60;
      m = minutes % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   function automatic logic [15:0] model_buf();
      logic [15:0] v;
      v = '0;
      foreach (m_dig[i]) v = v * 16 + 16'(m_dig[i]);
      return v;
   endfunction

   function automatic int digit_at(input int pos);
      int idx;
      idx = pos - (4 - m_dig.size());
      return (idx < 0) ? 0 : m_dig[idx];
   endfunction

   task automatic model_reset();
      m_min = 0; m_alarm = 0; m_pre = 0; m_idle = 0;
      m_dig.delete();
      m_entry = 0; m_err = 0; m_tick = 0; m_show_a = 0;
   endtask

   task automatic push_digit(input int d);
      m_dig.push_back(d);
      if (m_dig.size() > 4) void'(m_dig.pop_front());
   endtask

   task automatic step(input logic [3:0] k, input bit kv, input bit lnt, input bit la, input bit ab);
      int h, mm;
      bit loaded, term;
      key = k; key_valid = kv; load_new_time = lnt; load_alarm = la; alarm_button = ab;
      loaded = 0;
      term = (m_pre == CPM - 1);
      m_err = 0; m_tick = 0; m_show_a = ab;
      if (m_entry && (lnt || la)) begin
         h  = digit_at(0) * 10 + digit_at(1);
         mm = digit_at(2) * 10 + digit_at(3);
         if (h < 24 && mm < 60) begin
            if (lnt) begin m_min = h * 60 + mm; loaded = 1; end
            else m_alarm = h * 60 + mm;
         end else m_err = 1;
         m_dig.delete();
         m_entry = 0;
      end else if (m_entry) begin
         if (kv) begin
            m_idle = 0;
            if (k < 10) push_digit(int'(k));
         end
`ifdef ALARM_KEY_TIMEOUT_EN
         else begin
            m_idle++;
            if (m_idle == TO) begin m_dig.delete(); m_entry = 0; m_idle = 0; end
         end
`endif
      end else if (kv && k < 10) begin
         push_digit(int'(k));
         m_entry = 1;
         m_idle = 0;
      end
      if (loaded) m_pre = 0;
      else begin
         if (term) begin m_min = (m_min + 1) % 1440; m_tick = 1; end
         m_pre = (m_pre + 1) % CPM;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic press(input int d);
      step(4'(d), 1, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1; key = 0; key_valid = 0; load_alarm = 0; load_new_time = 0; alarm_button = 0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      n_tests++; if (current_time !== 16'h0) begin n_fail++; $display("FAIL reset_time: got %h want 0000", current_time); end
      n_tests++; if (alarm_time !== 16'h0) begin n_fail++; $display("FAIL reset_alarm: got %h want 0000", alarm_time); end
      n_tests++; if (key_buffer !== 16'h0) begin n_fail++; $display("FAIL reset_buf: got %h want 0000", key_buffer); end
      n_tests++; if ({show_a, show_new_time, load_error, minute_tick} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000", {show_a, show_new_time, load_error, minute_tick}); end
      reset = 0;
   endtask

   task automatic test_minute_count();
      for (int i = 0; i < 8; i++) begin
         idle(1);
         n_tests++; if (minute_tick !== ((i == 3) || (i == 7))) begin
            n_fail++; $display("FAIL minute_tick cycle %0d: got %b want %b", i, minute_tick, (i == 3) || (i == 7)); end
      end
      n_tests++; if (current_time !== 16'h0002) begin n_fail++; $display("FAIL count_8: got %h want 0002", current_time); end
   endtask

   task automatic test_load_time();
      press(2); press(3); press(5); press(9);
      n_tests++; if (key_buffer !== 16'h2359 || show_new_time !== 1'b1) begin
         n_fail++; $display("FAIL entry_2359: buf %h show %b want 2359 1", key_buffer, show_new_time); end
      step(4'd0, 0, 1, 0, 0);
      n_tests++; if (current_time !== 16'h2359 || key_buffer !== 16'h0 || show_new_time !== 1'b0) begin
         n_fail++; $display("FAIL load_time: time %h buf %h show %b want 2359 0000 0", current_time, key_buffer, show_new_time); end
      for (int i = 0; i < 3; i++) begin
         idle(1);
         n_tests++; if (current_time !== 16'h2359 || minute_tick !== 1'b0) begin
            n_fail++; $display("FAIL hold_2359 cycle %0d: time %h tick %b want 2359 0", i, current_time, minute_tick); end
      end
      idle(1);
      n_tests++; if (current_time !== 16'h0000 || minute_tick !== 1'b1) begin
         n_fail++; $display("FAIL wrap_midnight: time %h tick %b want 0000 1", current_time, minute_tick); end
   endtask

   task automatic test_load_alarm();
      press(0); press(7); press(3); press(0);
      n_tests++; if (key_buffer !== 16'h0730) begin n_fail++; $display("FAIL entry_0730: got %h want 0730", key_buffer); end
      step(4'd0, 0, 0, 1, 0);
      n_tests++; if (alarm_time !== 16'h0730) begin n_fail++; $display("FAIL load_alarm: got %h want 0730", alarm_time); end
      n_tests++; if (show_a !== 1'b0) begin n_fail++; $display("FAIL show_a_low: got %b want 0", show_a); end
      step(4'd0, 0, 0, 0, 1);
      n_tests++; if (show_a !== 1'b1) begin n_fail++; $display("FAIL show_a_rise: got %b want 1", show_a); end
      idle(3);
      n_tests++; if (show_a !== 1'b0) begin n_fail++; $display("FAIL show_a_fall: got %b want 0", show_a); end
      n_tests++; if (current_time !== bcd_of(m_min)) begin
         n_fail++; $display("FAIL time_running: got %h want %h", current_time, bcd_of(m_min)); end
   endtask

   task automatic test_load_error();
      press(2); press(4); press(0); press(0);
      step(4'd0, 0, 0, 1, 0);
      n_tests++; if (load_error !== 1'b1 || alarm_time !== 16'h0730 || key_buffer !== 16'h0 || show_new_time !== 1'b0) begin
         n_fail++; $display("FAIL reject_2400: err %b alarm %h buf %h show %b want 1 0730 0000 0",
                            load_error, alarm_time, key_buffer, show_new_time); end
      idle(1);
      n_tests++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0", load_error); end
      press(1); press(2); press(6); press(0);
      step(4'd0, 0, 0, 1, 0);
      n_tests++; if (load_error !== 1'b1 || alarm_time !== 16'h0730) begin
         n_fail++; $display("FAIL reject_1260: err %b alarm %h want 1 0730", load_error, alarm_time); end
   endtask

   task automatic test_simultaneous();
      press(1); press(2);
      n_tests++; if (key_buffer !== 16'h0012) begin n_fail++; $display("FAIL entry_0012: got %h want 0012", key_buffer); end
      step(4'd5, 1, 1, 1, 0);
      n_tests++; if (current_time !== 16'h0012 || alarm_time !== 16'h0730 || key_buffer !== 16'h0 || load_error !== 1'b0) begin
         n_fail++; $display("FAIL simultaneous: time %h alarm %h buf %h err %b want 0012 0730 0000 0",
                            current_time, alarm_time, key_buffer, load_error); end
      step(4'd0, 0, 0, 1, 0);
      n_tests++; if (current_time !== 16'h0012 || alarm_time !== 16'h0730 || load_error !== 1'b0 || show_new_time !== 1'b0) begin
         n_fail++; $display("FAIL idle_load_ignored: time %h alarm %h err %b show %b want 0012 0730 0 0",
                            current_time, alarm_time, load_error, show_new_time); end
   endtask

`ifdef ALARM_KEY_TIMEOUT_EN
   task automatic test_entry_timeout();
      press(1);
      idle(TO - 1);
      n_tests++; if (key_buffer !== 16'h0001 || show_new_time !== 1'b1) begin
         n_fail++; $display("FAIL before_timeout: buf %h show %b want 0001 1", key_buffer, show_new_time); end
      idle(1);
      n_tests++; if (key_buffer !== 16'h0 || show_new_time !== 1'b0 || load_error !== 1'b0) begin
         n_fail++; $display("FAIL timeout: buf %h show %b err %b want 0000 0 0", key_buffer, show_new_time, load_error); end
      press(1); idle(TO - 1); press(2); idle(TO - 1); press(3); idle(TO - 1);
      n_tests++; if (key_buffer !== 16'h0123 || show_new_time !== 1'b1) begin
         n_fail++; $display("FAIL entry_retained: buf %h show %b want 0123 1", key_buffer, show_new_time); end
   endtask
`else
   task automatic test_entry_persist();
      press(1);
      idle(40);
      n_tests++; if (key_buffer !== 16'h0001 || show_new_time !== 1'b1) begin
         n_fail++; $display("FAIL entry_persist: buf %h show %b want 0001 1", key_buffer, show_new_time); end
      step(4'd0, 0, 0, 1, 0);
      n_tests++; if (alarm_time !== 16'h0001) begin n_fail++; $display("FAIL late_alarm_load: got %h want 0001", alarm_time); end
   endtask
`endif

   task automatic test_random();
      bit kv, lnt, la, ab;
      logic [3:0] k;
      for (int i = 0; i < 600; i++) begin
         kv  = ($urandom_range(0, 2) == 0);
         k   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         lnt = ($urandom_range(0, 9) == 0);
         la  = ($urandom_range(0, 9) == 0);
         ab  = $urandom_range(0, 1) == 1;
         step(k, kv, lnt, la, ab);
         n_tests++; if (current_time !== bcd_of(m_min)) begin
            n_fail++; $display("FAIL rnd_time cycle %0d: got %h want %h", i, current_time, bcd_of(m_min)); end
         n_tests++; if (alarm_time !== bcd_of(m_alarm)) begin
            n_fail++; $display("FAIL rnd_alarm cycle %0d: got %h want %h", i, alarm_time, bcd_of(m_alarm)); end
         n_tests++; if (key_buffer !== model_buf()) begin
            n_fail++; $display("FAIL rnd_buf cycle %0d: got %h want %h", i, key_buffer, model_buf()); end
         n_tests++; if ({show_a, show_new_time, load_error, minute_tick} !== {m_show_a, m_entry, m_err, m_tick}) begin
            n_fail++; $display("FAIL rnd_flags cycle %0d: got %b want %b", i,
                               {show_a, show_new_time, load_error, minute_tick}, {m_show_a, m_entry, m_err, m_tick}); end
      end
   endtask

   task automatic test_reset_mid_entry();
      press(4); press(2);
      step(4'd0, 0, 0, 0, 1);
      reset = 1;
      #1;
      n_tests++; if ({current_time, alarm_time, key_buffer} !== 48'h0) begin
         n_fail++; $display("FAIL async_reset_buses: got %h want 0", {current_time, alarm_time, key_buffer}); end
      n_tests++; if ({show_a, show_new_time, load_error, minute_tick} !== 4'b0) begin
         n_fail++; $display("FAIL async_reset_flags: got %b want 0000", {show_a, show_new_time, load_error, minute_tick}); end
      @(posedge clock);
      #1;
      reset = 0;
      model_reset();
      idle(CPM);
      n_tests++; if (current_time !== 16'h0001 || show_new_time !== 1'b0) begin
         n_fail++; $display("FAIL after_reset: time %h show %b want 0001 0", current_time, show_new_time); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_minute_count();
      test_load_time();
      test_load_alarm();
      test_load_error();
      test_simultaneous();
`ifdef ALARM_KEY_TIMEOUT_EN
      test_entry_timeout();
`else
      test_entry_persist();
`endif
      test_random();
      test_reset_mid_entry();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
